// File: rtl/mult_pkg.sv
// Shared definitions for the approximate-multiplier error sweep.
// Holds the operand/result widths, the sweep length, the metric widths,
// the sweep FSM state type and the delay-line stage record.
package mult_pkg;

  localparam int unsigned OPW       = 4;    // MUT operand width
  localparam int unsigned RW        = 8;    // MUT result width
  localparam int unsigned NUM_PAIRS = 256;  // every {a,b} combination
  localparam int unsigned IDXW      = 8;    // sweep index width
  localparam int unsigned CNT_W     = 9;    // err_count: 0..256
  localparam int unsigned SUM_W     = 16;   // sum_abs_err: max 65280
  localparam int unsigned SSUM_W    = 18;   // signed error sum

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // One sample in flight between operand issue and result consumption.
  typedef struct packed {
    logic           vld;
    logic [RW-1:0]  exact;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } stage_t;

endpackage

// File: rtl/mult_err_sweep_err_accum.sv
// err_accum: per-sample error metric accumulator.
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_clear                synchronous clear of all metrics (start of sweep)
//   i_valid                sample present this cycle
//   i_exact, i_result      exact product and MUT product for the sample
//   i_a, i_b               operands of the sample (for worst-case capture)
//   o_err_count ... o_worst_b  registered metrics
module err_accum
  import mult_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [RW-1:0]     i_exact,
  input  logic [RW-1:0]     i_result,
  input  logic [OPW-1:0]    i_a,
  input  logic [OPW-1:0]    i_b,
  output logic [CNT_W-1:0]  o_err_count,
  output logic [SUM_W-1:0]  o_sum_abs_err,
  output logic [SSUM_W-1:0] o_sum_signed_err,
  output logic [RW-1:0]     o_max_abs_err,
  output logic [OPW-1:0]    o_worst_a,
  output logic [OPW-1:0]    o_worst_b
);

  logic [RW:0]   w_diff;
  logic [RW:0]   w_neg;
  logic [RW-1:0] w_abs;

  // 9-bit signed difference; |diff| always fits in 8 bits (max 255).
  always_comb begin
    w_diff = {1'b0, i_result} - {1'b0, i_exact};
    w_neg  = -w_diff;
    w_abs  = w_diff[RW] ? w_neg[RW-1:0] : w_diff[RW-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_count      <= '0;
      o_sum_abs_err    <= '0;
      o_sum_signed_err <= '0;
      o_max_abs_err    <= '0;
      o_worst_a        <= '0;
      o_worst_b        <= '0;
    end else if (i_clear) begin
      o_err_count      <= '0;
      o_sum_abs_err    <= '0;
      o_sum_signed_err <= '0;
      o_max_abs_err    <= '0;
      o_worst_a        <= '0;
      o_worst_b        <= '0;
    end else if (i_valid) begin
      o_err_count      <= o_err_count + CNT_W'(w_abs != '0);
      o_sum_abs_err    <= o_sum_abs_err + SUM_W'(w_abs);
      o_sum_signed_err <= o_sum_signed_err + {{(SSUM_W-RW-1){w_diff[RW]}}, w_diff};
      // Strict compare: the first pair reaching the maximum is kept.
      if (w_abs > o_max_abs_err) begin
        o_max_abs_err <= w_abs;
        o_worst_a     <= i_a;
        o_worst_b     <= i_b;
      end
    end
  end

endmodule

// File: rtl/mult_err_sweep.sv
// mult_err_sweep: drives all 256 operand pairs into a 4x4 approximate
// multiplier, compares each result with the exact product and accumulates
// error metrics.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             begins a sweep when IDLE or DONE
//   mul_a, mul_b      registered operands to the MUT (A is the outer loop)
//   mul_result        MUT product, valid MUL_LATENCY cycles after operands
//   busy              sweep or drain in progress
//   done              sweep finished; metrics valid until next start
//   err_count, sum_abs_err, sum_signed_err, max_abs_err, worst_a, worst_b
//                     accumulated error metrics
module mult_err_sweep
  import mult_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [OPW-1:0]    mul_a,
  output logic [OPW-1:0]    mul_b,
  input  logic [RW-1:0]     mul_result,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic [SUM_W-1:0]  sum_abs_err,
  output logic [SSUM_W-1:0] sum_signed_err,
  output logic [RW-1:0]     max_abs_err,
  output logic [OPW-1:0]    worst_a,
  output logic [OPW-1:0]    worst_b
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDXW-1:0] r_idx;
  logic [OPW-1:0]  r_mul_a;
  logic [OPW-1:0]  r_mul_b;
  stage_t          r_dly [MUL_LATENCY+1];
  stage_t          w_new;
  logic            w_accept;
  logic            w_issue;
  logic            w_upstream;

  // Stage 0 is loaded together with the operand registers; the last stage
  // lines up with mul_result and is the one consumed.
  always_comb begin
    w_accept   = ((r_state == IDLE) || (r_state == DONE)) && start;
    w_issue    = (r_state == RUN);
    w_new.vld  = w_issue;
    w_new.a    = r_idx[IDXW-1:OPW];
    w_new.b    = r_idx[OPW-1:0];
    w_new.exact = {{(RW-OPW){1'b0}}, r_idx[IDXW-1:OPW]} *
                  {{(RW-OPW){1'b0}}, r_idx[OPW-1:0]};
    // Any valid sample still ahead of the consumed stage keeps DRAIN going.
    w_upstream = 1'b0;
    for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
      w_upstream = w_upstream | r_dly[i].vld;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_idx == IDXW'(NUM_PAIRS - 1)) w_state_nxt = DRAIN;
      DRAIN:   if (!w_upstream) w_state_nxt = DONE;
      DONE:    if (start) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx <= '0;
      end else if (w_issue) begin
        r_mul_a <= r_idx[IDXW-1:OPW];
        r_mul_b <= r_idx[OPW-1:0];
        if (r_idx != '1) r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= MUL_LATENCY; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= w_new;
      for (int unsigned i = 1; i <= MUL_LATENCY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  err_accum u_accum (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_clear          (w_accept),
    .i_valid          (r_dly[MUL_LATENCY].vld),
    .i_exact          (r_dly[MUL_LATENCY].exact),
    .i_result         (mul_result),
    .i_a              (r_dly[MUL_LATENCY].a),
    .i_b              (r_dly[MUL_LATENCY].b),
    .o_err_count      (err_count),
    .o_sum_abs_err    (sum_abs_err),
    .o_sum_signed_err (sum_signed_err),
    .o_max_abs_err    (max_abs_err),
    .o_worst_a        (worst_a),
    .o_worst_b        (worst_b)
  );

  assign mul_a = r_mul_a;
  assign mul_b = r_mul_b;
  assign busy  = (r_state == RUN) || (r_state == DRAIN);
  assign done  = (r_state == DONE);

endmodule

// File: tb/tb_mult_err_sweep.sv
// Scoreboard bench for mult_err_sweep: two instances (MUL_LATENCY 0 and 2)
// share start/reset and see the same MUT function.
module tb_mult_err_sweep;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic [3:0]  a0, b0, a2, b2, wa0, wb0, wa2, wb2;
  logic [7:0]  res0, res2, mx0, mx2;
  logic        busy0, busy2, done0, done2;
  logic [8:0]  cnt0, cnt2;
  logic [15:0] sabs0, sabs2;
  logic [17:0] ssum0, ssum2;

  always #5 clk = ~clk;

  mult_err_sweep #(.MUL_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mul_a(a0), .mul_b(b0),
    .mul_result(res0), .busy(busy0), .done(done0), .err_count(cnt0),
    .sum_abs_err(sabs0), .sum_signed_err(ssum0), .max_abs_err(mx0),
    .worst_a(wa0), .worst_b(wb0));

  mult_err_sweep #(.MUL_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mul_a(a2), .mul_b(b2),
    .mul_result(res2), .busy(busy2), .done(done2), .err_count(cnt2),
    .sum_abs_err(sabs2), .sum_signed_err(ssum2), .max_abs_err(mx2),
    .worst_a(wa2), .worst_b(wb2));

  // MUT behaviour: 0 exact, 1 all-zero, 2 all-ones, 3 exact^small, 4 random
  int         mode = 0;
  logic [7:0] tbl [256];
  logic [7:0] p1, p2;

  function automatic logic [7:0] mut_f(input int md, input logic [3:0] a,
                                       input logic [3:0] b, input logic [7:0] t);
    logic [7:0] ex;
    ex = {4'b0, a} * {4'b0, b};
    case (md)
      0: return ex;
      1: return 8'h00;
      2: return 8'hFF;
      3: return ex ^ t;
      default: return t;
    endcase
  endfunction

  always_comb res0 = mut_f(mode, a0, b0, tbl[{a0, b0}]);

  always @(posedge clk) begin
    p1 <= mut_f(mode, a2, b2, tbl[{a2, b2}]);
    p2 <= p1;
  end
  assign res2 = p2;

  typedef struct {
    int cnt; int sabs; int ssum; int mx; int wa; int wb;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: walk all pairs, A outer, using plain integer arithmetic.
  function automatic exp_t model();
    exp_t e;
    e = '{default: 0};
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int ex, r, d, ad;
        ex = a * b;
        r  = int'(mut_f(mode, a[3:0], b[3:0], tbl[a * 16 + b]));
        d  = r - ex;
        ad = (d < 0) ? -d : d;
        if (ad != 0) e.cnt++;
        e.sabs += ad;
        e.ssum += d;
        if (ad > e.mx) begin
          e.mx = ad; e.wa = a; e.wb = b;
        end
      end
    end
    return e;
  endfunction

  task automatic cmp_metrics(input string tag, input exp_t e, input int cnt,
                             input int sabs, input int ssum, input int mx,
                             input int wa, input int wb);
    chk({tag, " err_count"}, cnt, e.cnt);
    chk({tag, " sum_abs_err"}, sabs, e.sabs);
    chk({tag, " sum_signed_err"}, ssum, e.ssum);
    chk({tag, " max_abs_err"}, mx, e.mx);
    chk({tag, " worst_a"}, wa, e.wa);
    chk({tag, " worst_b"}, wb, e.wb);
  endtask

  // Monitor: compares metrics whenever a DUT raises done.
  logic pd0 = 1'b0;
  logic pd2 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done0 && !pd0) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut0 unexpected done: got done with empty queue, expected none");
      end else begin
        e = q0.pop_front();
        cmp_metrics("dut0", e, cnt0, sabs0, $signed(ssum0), mx0, wa0, wb0);
      end
    end
    if (done2 && !pd2) begin
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut2 unexpected done: got done with empty queue, expected none");
      end else begin
        e = q2.pop_front();
        cmp_metrics("dut2", e, cnt2, sabs2, $signed(ssum2), mx2, wa2, wb2);
      end
    end
    pd0 = done0;
    pd2 = done2;
  end

  task automatic prep(input int md);
    mode = md;
    for (int i = 0; i < 256; i++)
      tbl[i] = (md == 3) ? 8'($urandom_range(0, 7)) : 8'($urandom);
  endtask

  task automatic issue_start();
    exp_t e;
    e = model();
    q0.push_back(e);
    q2.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dut0 busy after start", busy0, 1);
    chk("dut2 busy after start", busy2, 1);
    chk("dut0 done after start", done0, 0);
    chk("dut2 done after start", done2, 0);
    chk("dut0 cleared metrics", cnt0 + sabs0 + mx0, 0);
    chk("dut2 cleared metrics", cnt2 + sabs2 + mx2, 0);
  endtask

  // Cycle k counts rising edges after the start edge.
  task automatic wait_done(input int extra_start);
    int d0, d2;
    d0 = -1;
    d2 = -1;
    for (int k = 1; k <= 400 && (d0 < 0 || d2 < 0); k++) begin
      @(negedge clk);
      if (k == extra_start) start = 1'b1;
      else if (k == extra_start + 1) start = 1'b0;
      if (k <= 256) begin
        chk("dut0 operands", {a0, b0}, k - 1);
        chk("dut2 operands", {a2, b2}, k - 1);
      end
      if (done0 && d0 < 0) begin d0 = k; chk("dut0 busy at done", busy0, 0); end
      if (done2 && d2 < 0) begin d2 = k; chk("dut2 busy at done", busy2, 0); end
    end
    chk("dut0 done latency", d0, 257);
    chk("dut2 done latency", d2, 259);
  endtask

  task automatic chk_zero(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic bs, input logic dn, input logic [8:0] cnt,
                          input logic [15:0] sabs, input logic [17:0] ssum,
                          input logic [7:0] mx, input logic [3:0] wa, input logic [3:0] wb);
    chk({tag, " reset operands"}, {a, b}, 0);
    chk({tag, " reset busy/done"}, {bs, dn}, 0);
    chk({tag, " reset err_count"}, cnt, 0);
    chk({tag, " reset sum_abs_err"}, sabs, 0);
    chk({tag, " reset sum_signed_err"}, ssum, 0);
    chk({tag, " reset max/worst"}, {mx, wa, wb}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero("dut0", a0, b0, busy0, done0, cnt0, sabs0, ssum0, mx0, wa0, wb0);
    chk_zero("dut2", a2, b2, busy2, done2, cnt2, sabs2, ssum2, mx2, wa2, wb2);
    rst_n = 1'b1;

    // Exact, all-zero and all-ones MUTs; later starts come from DONE.
    for (int md = 0; md < 3; md++) begin
      prep(md); issue_start(); wait_done(-1);
    end
    // Random approximate MUTs.
    for (int r = 0; r < 6; r++) begin
      prep(3 + (r % 2)); issue_start(); wait_done(-1);
    end
    // Start pulsed mid-sweep must be ignored.
    prep(3); issue_start(); wait_done(50);

    // Reset at index 100, then a clean rerun with the same MUT.
    prep(4); issue_start();
    for (int k = 1; k <= 101; k++) @(negedge clk);
    chk("operand before reset", {a0, b0}, 100);
    rst_n = 1'b0;
    #1;
    chk_zero("dut0", a0, b0, busy0, done0, cnt0, sabs0, ssum0, mx0, wa0, wb0);
    chk_zero("dut2", a2, b2, busy2, done2, cnt2, sabs2, ssum2, mx2, wa2, wb2);
    q0.delete();
    q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue_start(); wait_done(-1);

    repeat (3) @(negedge clk);
    chk("pending expectations", q0.size() + q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
